// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter: round-robin sharing of one DDR3 app interface between two requesters,
// one burst per grant, read data routed back through an in-order port-tag FIFO.
module ddr3_app_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 256,
    parameter int MASK_W = 32,
    parameter int RD_DEPTH = 8,
    parameter logic [2:0] CMD_WRITE = 3'b000,
    parameter logic [2:0] CMD_READ = 3'b001
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              init_calib_complete_i,
    input  logic              rq0_valid_i,
    input  logic              rq0_write_i,
    input  logic [ADDR_W-1:0] rq0_addr_i,
    input  logic [DATA_W-1:0] rq0_wdata_i,
    input  logic [MASK_W-1:0] rq0_mask_i,
    output logic              rq0_ready_o,
    output logic [DATA_W-1:0] rq0_rd_data_o,
    output logic              rq0_rd_valid_o,
    input  logic              rq1_valid_i,
    input  logic              rq1_write_i,
    input  logic [ADDR_W-1:0] rq1_addr_i,
    input  logic [DATA_W-1:0] rq1_wdata_i,
    input  logic [MASK_W-1:0] rq1_mask_i,
    output logic              rq1_ready_o,
    output logic [DATA_W-1:0] rq1_rd_data_o,
    output logic              rq1_rd_valid_o,
    output logic [2:0]        app_cmd_o,
    output logic              app_en_o,
    output logic [ADDR_W-1:0] app_addr_o,
    input  logic              app_rdy_i,
    output logic [DATA_W-1:0] app_wdf_data_o,
    output logic [MASK_W-1:0] app_wdf_mask_o,
    output logic              app_wdf_end_o,
    output logic              app_wdf_wren_o,
    input  logic              app_wdf_rdy_i,
    input  logic [DATA_W-1:0] app_rd_data_i,
    input  logic              app_rd_data_valid_i,
    output logic              rd_err_o
);
    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state_q, state_d;
    logic              port_q, pref_q, cmd_pend_q, wd_pend_q, rd_err_q;
    logic [2:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rd_data_q;
    logic [MASK_W-1:0] mask_q;
    logic [RD_DEPTH-1:0] tag_q;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        rd_valid_q;
    logic full, el0, el1, win, grant, done, push, pop;
    assign full  = cnt_q == CW'(RD_DEPTH);
    assign el0   = rq0_valid_i & (rq0_write_i | ~full);
    assign el1   = rq1_valid_i & (rq1_write_i | ~full);
    assign win   = (el0 & el1) ? pref_q : el1;
    assign grant = init_calib_complete_i & (el0 | el1);
    // Transaction completes once neither handshake is still outstanding after this cycle's fires.
    assign done  = (state_q == ISSUE) & ~(cmd_pend_q & ~app_rdy_i) & ~(wd_pend_q & ~app_wdf_rdy_i);
    assign push  = cmd_pend_q & app_rdy_i & (cmd_q == CMD_READ);
    assign pop   = app_rd_data_valid_i & (cnt_q != '0);
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (grant ? ISSUE : IDLE) : (done ? IDLE : ISSUE);
    end
    always_comb begin
        app_en_o       = cmd_pend_q & app_rdy_i;
        app_wdf_wren_o = wd_pend_q & app_wdf_rdy_i;
        app_wdf_end_o  = wd_pend_q & app_wdf_rdy_i;
        rq0_ready_o    = done & ~port_q;
        rq1_ready_o    = done & port_q;
        app_cmd_o      = cmd_q;
        app_addr_o     = addr_q;
        app_wdf_data_o = wdata_q;
        app_wdf_mask_o = mask_q;
        rq0_rd_data_o  = rd_data_q;
        rq1_rd_data_o  = rd_data_q;
        rq0_rd_valid_o = rd_valid_q[0];
        rq1_rd_valid_o = rd_valid_q[1];
        rd_err_o       = rd_err_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            port_q     <= 1'b0;
            pref_q     <= 1'b0;
            cmd_pend_q <= 1'b0;
            wd_pend_q  <= 1'b0;
            cmd_q      <= CMD_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            tag_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && grant) begin
                port_q     <= win;
                pref_q     <= ~win;
                cmd_pend_q <= 1'b1;
                wd_pend_q  <= win ? rq1_write_i : rq0_write_i;
                cmd_q      <= (win ? rq1_write_i : rq0_write_i) ? CMD_WRITE : CMD_READ;
                addr_q     <= win ? rq1_addr_i : rq0_addr_i;
                wdata_q    <= win ? rq1_wdata_i : rq0_wdata_i;
                mask_q     <= win ? rq1_mask_i : rq0_mask_i;
            end else begin
                cmd_pend_q <= cmd_pend_q & ~app_rdy_i;
                wd_pend_q  <= wd_pend_q & ~app_wdf_rdy_i;
            end
            if (push) begin
                tag_q[wptr_q] <= port_q;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q      <= cnt_q + CW'(push) - CW'(pop);
            rd_valid_q <= {pop & tag_q[rptr_q], pop & ~tag_q[rptr_q]};
            if (app_rd_data_valid_i) rd_data_q <= app_rd_data_i;
            if (app_rd_data_valid_i && cnt_q == '0) rd_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// tb_ddr3_app_arbiter: directed scenario tasks for the two-port DDR3 app arbiter,
// each comparing outputs against hand-computed values.
module tb_ddr3_app_arbiter;
    localparam int RD_DEPTH = 8;
    logic         clk = 1'b0;
    logic         rst_n, calib;
    logic         rq0_valid, rq0_write, rq0_ready, rq0_rd_valid;
    logic [27:0]  rq0_addr;
    logic [255:0] rq0_wdata, rq0_rd_data;
    logic [31:0]  rq0_mask;
    logic         rq1_valid, rq1_write, rq1_ready, rq1_rd_valid;
    logic [27:0]  rq1_addr;
    logic [255:0] rq1_wdata, rq1_rd_data;
    logic [31:0]  rq1_mask;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_end, app_wdf_wren, app_wdf_rdy;
    logic         app_rd_data_valid, rd_err;
    logic [27:0]  app_addr;
    logic [255:0] app_wdf_data, app_rd_data;
    logic [31:0]  app_wdf_mask;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr3_app_arbiter #(.RD_DEPTH(RD_DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .init_calib_complete_i(calib),
        .rq0_valid_i(rq0_valid), .rq0_write_i(rq0_write), .rq0_addr_i(rq0_addr),
        .rq0_wdata_i(rq0_wdata), .rq0_mask_i(rq0_mask), .rq0_ready_o(rq0_ready),
        .rq0_rd_data_o(rq0_rd_data), .rq0_rd_valid_o(rq0_rd_valid),
        .rq1_valid_i(rq1_valid), .rq1_write_i(rq1_write), .rq1_addr_i(rq1_addr),
        .rq1_wdata_i(rq1_wdata), .rq1_mask_i(rq1_mask), .rq1_ready_o(rq1_ready),
        .rq1_rd_data_o(rq1_rd_data), .rq1_rd_valid_o(rq1_rd_valid),
        .app_cmd_o(app_cmd), .app_en_o(app_en), .app_addr_o(app_addr), .app_rdy_i(app_rdy),
        .app_wdf_data_o(app_wdf_data), .app_wdf_mask_o(app_wdf_mask), .app_wdf_end_o(app_wdf_end),
        .app_wdf_wren_o(app_wdf_wren), .app_wdf_rdy_i(app_wdf_rdy),
        .app_rd_data_i(app_rd_data), .app_rd_data_valid_i(app_rd_data_valid), .rd_err_o(rd_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
        $fatal(1);
    end

    task automatic idle_inputs();
        calib = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        rq0_valid = 1'b0; rq0_write = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_mask = '0;
        rq1_valid = 1'b0; rq1_write = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_mask = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    // Presents one request on port p and waits (bounded) for its ready pulse.
    task automatic do_txn(input bit p, input bit wr, input logic [27:0] a,
                          input logic [255:0] d, output bit ok);
        ok = 1'b0;
        if (!p) begin rq0_valid = 1'b1; rq0_write = wr; rq0_addr = a; rq0_wdata = d; rq0_mask = 32'h0F; end
        else    begin rq1_valid = 1'b1; rq1_write = wr; rq1_addr = a; rq1_wdata = d; rq1_mask = 32'hF0; end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            if (p ? rq1_ready : rq0_ready) begin ok = 1'b1; break; end
        end
        if (!p) rq0_valid = 1'b0; else rq1_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 28'h40;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL reset_app_en got=%b exp=0", app_en); end
        checks++; if (app_wdf_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", app_wdf_wren); end
        checks++; if (app_cmd !== 3'b001) begin failures++; $display("FAIL reset_app_cmd got=%b exp=001", app_cmd); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
        checks++; if (rq0_ready !== 1'b0) begin failures++; $display("FAIL reset_rq0_ready got=%b exp=0", rq0_ready); end
        rq0_valid = 1'b0;
    endtask

    task automatic test_calib_gate();
        bit bad = 1'b0;
        do_reset();
        calib = 1'b0;
        rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 28'h40; rq0_wdata = {8{32'hCAFE0040}}; rq0_mask = 32'h3;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (app_en || app_wdf_wren || rq0_ready) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL calib_gate_activity got=%b exp=0", bad); end
        calib = 1'b1;
        @(posedge clk); #2;
        checks++; if (app_en !== 1'b1) begin failures++; $display("FAIL calib_app_en got=%b exp=1", app_en); end
        checks++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin failures++; $display("FAIL calib_wren got=%b%b exp=11", app_wdf_wren, app_wdf_end); end
        checks++; if (rq0_ready !== 1'b1) begin failures++; $display("FAIL calib_rq0_ready got=%b exp=1", rq0_ready); end
        checks++; if (app_addr !== 28'h40 || app_cmd !== 3'b000) begin failures++; $display("FAIL calib_cmd got=%h/%b exp=40/000", app_addr, app_cmd); end
        checks++; if (app_wdf_data !== {8{32'hCAFE0040}} || app_wdf_mask !== 32'h3) begin failures++; $display("FAIL calib_wdata got=%h mask=%h exp=cafe0040.. mask=3", app_wdf_data[31:0], app_wdf_mask); end
        rq0_valid = 1'b0;
        @(posedge clk); #2;
        checks++; if (rq0_ready !== 1'b0 || app_en !== 1'b0) begin failures++; $display("FAIL calib_single_pulse got=%b%b exp=00", rq0_ready, app_en); end
    endtask

    task automatic test_contention();
        int n = 0, c0 = 0, c1 = 0;
        do_reset();
        rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 28'h100; rq0_wdata = {8{32'h00000000}};
        rq1_valid = 1'b1; rq1_write = 1'b1; rq1_addr = 28'h208; rq1_wdata = {8{32'h11111111}};
        for (int i = 0; i < 40 && n < 8; i++) begin
            @(posedge clk); #2;
            if (rq0_ready) c0++;
            if (rq1_ready) c1++;
            if (app_en) begin
                checks++;
                if (app_addr !== ((n % 2) ? 28'h208 : 28'h100) || (n % 2 ? rq1_ready : rq0_ready) !== 1'b1) begin
                    failures++;
                    $display("FAIL contention_grant%0d got addr=%h r0=%b r1=%b exp port=%0d", n, app_addr, rq0_ready, rq1_ready, n % 2);
                end
                n++;
            end
        end
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        checks++; if (n !== 8) begin failures++; $display("FAIL contention_txns got=%0d exp=8", n); end
        checks++; if (c0 !== 4 || c1 !== 4) begin failures++; $display("FAIL contention_ready_counts got=%0d/%0d exp=4/4", c0, c1); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_split_handshake();
        do_reset();
        app_wdf_rdy = 1'b0;
        rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 28'h80; rq0_wdata = {8{32'hBEEF0080}};
        @(posedge clk); #2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (app_en !== (i == 0) || app_wdf_wren !== 1'b0 || rq0_ready !== 1'b0) begin
                failures++;
                $display("FAIL split_wait%0d got en=%b wren=%b rdy=%b exp en=%b wren=0 rdy=0", i, app_en, app_wdf_wren, rq0_ready, i == 0);
            end
            @(posedge clk); #2;
        end
        app_wdf_rdy = 1'b1; #1;
        checks++; if (app_wdf_wren !== 1'b1 || app_en !== 1'b0) begin failures++; $display("FAIL split_wren got wren=%b en=%b exp 1/0", app_wdf_wren, app_en); end
        checks++; if (rq0_ready !== 1'b1) begin failures++; $display("FAIL split_ready got=%b exp=1", rq0_ready); end
        checks++; if (app_wdf_data !== {8{32'hBEEF0080}}) begin failures++; $display("FAIL split_data got=%h exp=beef0080", app_wdf_data[31:0]); end
        rq0_valid = 1'b0;
        @(posedge clk); #2;
        checks++; if (rq0_ready !== 1'b0 || app_wdf_wren !== 1'b0) begin failures++; $display("FAIL split_after got rdy=%b wren=%b exp 0/0", rq0_ready, app_wdf_wren); end
    endtask

    task automatic test_read_routing();
        bit ok, bad;
        logic [255:0] d [3];
        bit prt [3];
        d[0] = {8{32'hD0D0D0D0}}; d[1] = {8{32'hD1D1D1D1}}; d[2] = {8{32'hD2D2D2D2}};
        prt[0] = 1'b0; prt[1] = 1'b1; prt[2] = 1'b0;
        do_reset();
        do_txn(1'b0, 1'b0, 28'h0, '0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL read_issue0 got=timeout exp=ready"); end
        do_txn(1'b1, 1'b0, 28'h8, '0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL read_issue1 got=timeout exp=ready"); end
        do_txn(1'b0, 1'b0, 28'h10, '0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL read_issue2 got=timeout exp=ready"); end
        checks++; if (app_cmd !== 3'b001 || app_addr !== 28'h10) begin failures++; $display("FAIL read_cmd got=%b/%h exp=001/10", app_cmd, app_addr); end
        for (int i = 0; i < 3; i++) begin
            app_rd_data_valid = 1'b1; app_rd_data = d[i];
            @(posedge clk); #1;
            app_rd_data_valid = 1'b0; #1;
            checks++;
            if (rq0_rd_valid !== !prt[i] || rq1_rd_valid !== prt[i] ||
                (prt[i] ? rq1_rd_data : rq0_rd_data) !== d[i]) begin
                failures++;
                $display("FAIL read_return%0d got v0=%b v1=%b data=%h exp port=%0d data=%h", i, rq0_rd_valid, rq1_rd_valid,
                         prt[i] ? rq1_rd_data[31:0] : rq0_rd_data[31:0], prt[i], d[i][31:0]);
            end
        end
        @(posedge clk); #2;
        checks++; if (rq0_rd_valid !== 1'b0 || rq1_rd_valid !== 1'b0 || rd_err !== 1'b0) begin failures++; $display("FAIL read_strobe_width got=%b%b err=%b exp=00 err=0", rq0_rd_valid, rq1_rd_valid, rd_err); end
        // Fill the tag FIFO, then a further read must stall while a write still gets through.
        do_reset();
        bad = 1'b0;
        for (int i = 0; i < RD_DEPTH; i++) begin
            do_txn(1'b0, 1'b0, 28'(i * 8), '0, ok);
            if (!ok) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL fill_reads got=timeout exp=%0d grants", RD_DEPTH); end
        rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 28'h400;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (app_en || rq0_ready) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL full_read_stall got=granted exp=stalled"); end
        do_txn(1'b1, 1'b1, 28'h500, {8{32'h55555555}}, ok);
        checks++; if (!ok || rq0_ready !== 1'b0) begin failures++; $display("FAIL full_write_pass got ok=%b r0=%b exp ok=1 r0=0", ok, rq0_ready); end
        app_rd_data_valid = 1'b1; app_rd_data = {8{32'h77777777}};
        @(posedge clk); #1;
        app_rd_data_valid = 1'b0; #1;
        checks++; if (rq0_rd_valid !== 1'b1) begin failures++; $display("FAIL full_pop_return got=%b exp=1", rq0_rd_valid); end
        do_txn(1'b0, 1'b0, 28'h400, '0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL unstall_read got=timeout exp=ready"); end
    endtask

    task automatic test_spurious();
        do_reset();
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL spur_pre got=%b exp=0", rd_err); end
        app_rd_data_valid = 1'b1; app_rd_data = {8{32'hDEADDEAD}};
        @(posedge clk); #1;
        app_rd_data_valid = 1'b0; #1;
        checks++; if (rq0_rd_valid !== 1'b0 || rq1_rd_valid !== 1'b0) begin failures++; $display("FAIL spur_no_valid got=%b%b exp=00", rq0_rd_valid, rq1_rd_valid); end
        checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL spur_err got=%b exp=1", rd_err); end
        repeat (5) @(posedge clk); #2;
        checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", rd_err); end
        rst_n = 1'b0;
        @(posedge clk); #2;
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL spur_reset_clear got=%b exp=0", rd_err); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_calib_gate();
        test_contention();
        test_split_handshake();
        test_read_routing();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
